store_queue_fwd: RTL and testbench

//  Parametrised store half of the load/store unit. Allocates up to WAYS stores per cycle in

---
 rtl/store_queue_fwd.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_store_queue_fwd.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_fwd.sv
// store_queue_fwd: circular store queue with multi-lane allocation, in-order commit,
// DCache drain over valid/ready, and a combinational store-to-load forwarding query.
module store_queue_fwd #(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ROB    = 32,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned PW    = IDX_W + 1,
    localparam int unsigned ROB_W = $clog2(ROB),
    localparam int unsigned RC_W  = $clog2(WAYS) + 1
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   except_i,
    input  logic [WAYS-1:0]        alloc_en_i,
    input  logic [WAYS*ROB_W-1:0]  alloc_rob_idx_i,
    input  logic [WAYS*2-1:0]      alloc_size_i,
    output logic [WAYS*IDX_W-1:0]  alloc_idx_o,
    output logic [PW-1:0]          sq_tail_o,
    output logic [PW-1:0]          free_cnt_o,
    input  logic [WAYS-1:0]        exe_valid_i,
    input  logic [WAYS*IDX_W-1:0]  exe_sq_idx_i,
    input  logic [WAYS*ADDR_W-1:0] exe_addr_i,
    input  logic [WAYS*64-1:0]     exe_data_i,
    input  logic [RC_W-1:0]        retire_cnt_i,
    input  logic                   ld_q_valid_i,
    input  logic [ADDR_W-1:0]      ld_q_addr_i,
    input  logic [1:0]             ld_q_size_i,
    input  logic [PW-1:0]          ld_q_tail_i,
    output logic                   fwd_hit_o,
    output logic [63:0]            fwd_data_o,
    output logic                   fwd_stall_o,
    output logic                   wr_valid_o,
    output logic [ADDR_W-1:0]      wr_addr_o,
    output logic [63:0]            wr_data_o,
    output logic [1:0]             wr_size_o,
    input  logic                   wr_ready_i
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned EW     = ADDR_W + 1;

    typedef enum logic [1:0] {
        E_EMPTY  = 2'd0,
        E_ALLOC  = 2'd1,
        E_READY  = 2'd2,
        E_COMMIT = 2'd3
    } ent_state_e;

    ent_state_e          st_q   [DEPTH];
    ent_state_e          st_d   [DEPTH];
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [ADDR_W-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [1:0]          size_q [DEPTH];
    logic [1:0]          size_d [DEPTH];

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       commit_q, commit_d;
    logic [PW-1:0]       tail_q, tail_d;

    logic [IDX_W-1:0]    head_idx_c;
    logic [RC_W-1:0]     alloc_cnt_c;
    logic                alloc_ok_c;
    logic                retire_ok_c;
    logic                pop_c;
    logic [IDX_W-1:0]    a_slot_c;
    logic [IDX_W-1:0]    e_slot_c;
    logic [IDX_W-1:0]    r_slot_c;
    logic [IDX_W-1:0]    c_slot_c;
    logic [IDX_W-1:0]    f_slot_c;
    logic [PW-1:0]       older_c;
    logic                any_alloc_c;
    logic                ov_found_c;
    logic                ov_cover_c;
    logic [2:0]          ov_off_c;
    logic [DATA_W-1:0]   ov_data_c;
    logic [EW-1:0]       ld_end_c;
    logic [EW-1:0]       st_end_c;

    // ROB tags travel with dispatch but no queue behaviour depends on them.
    logic                unused_rob_c;
    assign unused_rob_c = ^alloc_rob_idx_i;

    function automatic logic [3:0] size_bytes(input logic [1:0] s);
        return 4'd1 << s;
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] s);
        logic [DATA_W-1:0] m;
        case (s)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Occupancy, tail and drain port all come straight from registered state.
    assign head_idx_c = head_q[IDX_W-1:0];
    assign sq_tail_o  = tail_q;
    assign free_cnt_o = PW'(DEPTH) - (tail_q - head_q);
    assign wr_valid_o = (st_q[head_idx_c] == E_COMMIT);
    assign wr_addr_o  = addr_q[head_idx_c];
    assign wr_data_o  = data_q[head_idx_c];
    assign wr_size_o  = size_q[head_idx_c];
    assign pop_c      = wr_valid_o & wr_ready_i;

    // Enabled lanes take consecutive slots from tail; idle lanes report tail+k.
    always_comb begin
        alloc_idx_o = '0;
        alloc_cnt_c = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (alloc_en_i[k]) begin
                alloc_idx_o[k*IDX_W +: IDX_W] = tail_q[IDX_W-1:0] + IDX_W'(alloc_cnt_c);
                alloc_cnt_c = alloc_cnt_c + RC_W'(1);
            end else begin
                alloc_idx_o[k*IDX_W +: IDX_W] = tail_q[IDX_W-1:0] + IDX_W'(k);
            end
        end
        alloc_ok_c = (PW'(alloc_cnt_c) <= free_cnt_o);
    end

    // Retired stores must already hold their address and data.
    always_comb begin
        retire_ok_c = (PW'(retire_cnt_i) <= PW'(tail_q - commit_q));
        r_slot_c    = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (RC_W'(i) < retire_cnt_i) begin
                r_slot_c = commit_q[IDX_W-1:0] + IDX_W'(i);
                if (st_q[r_slot_c] != E_READY) begin
                    retire_ok_c = 1'b0;
                end
            end
        end
    end

    // Next state: alloc, exe write, retire, drain pop, then squash on except.
    always_comb begin
        head_d   = head_q;
        commit_d = commit_q;
        tail_d   = tail_q;
        a_slot_c = '0;
        e_slot_c = '0;
        c_slot_c = '0;
        for (int j = 0; j < DEPTH; j++) begin
            st_d[j]   = st_q[j];
            addr_d[j] = addr_q[j];
            data_d[j] = data_q[j];
            size_d[j] = size_q[j];
        end

        if (!except_i && alloc_ok_c) begin
            for (int k = 0; k < WAYS; k++) begin
                if (alloc_en_i[k]) begin
                    a_slot_c         = alloc_idx_o[k*IDX_W +: IDX_W];
                    st_d[a_slot_c]   = E_ALLOC;
                    size_d[a_slot_c] = alloc_size_i[k*2 +: 2];
                end
            end
            tail_d = tail_q + PW'(alloc_cnt_c);
        end

        if (!except_i) begin
            for (int k = 0; k < WAYS; k++) begin
                e_slot_c = exe_sq_idx_i[k*IDX_W +: IDX_W];
                if (exe_valid_i[k] && (st_q[e_slot_c] == E_ALLOC)) begin
                    st_d[e_slot_c]   = E_READY;
                    addr_d[e_slot_c] = exe_addr_i[k*ADDR_W +: ADDR_W];
                    data_d[e_slot_c] = exe_data_i[k*DATA_W +: DATA_W];
                end
            end
        end

        for (int i = 0; i < WAYS; i++) begin
            if (RC_W'(i) < retire_cnt_i) begin
                c_slot_c       = commit_q[IDX_W-1:0] + IDX_W'(i);
                st_d[c_slot_c] = E_COMMIT;
            end
        end
        commit_d = commit_q + PW'(retire_cnt_i);

        if (pop_c) begin
            st_d[head_idx_c] = E_EMPTY;
            head_d           = head_q + PW'(1);
        end

        if (except_i) begin
            tail_d = commit_d;
            for (int j = 0; j < DEPTH; j++) begin
                if ((st_d[j] == E_ALLOC) || (st_d[j] == E_READY)) begin
                    st_d[j] = E_EMPTY;
                end
            end
        end
    end

    // Forwarding: scan older slots oldest-first so the youngest overlap wins.
    always_comb begin
        fwd_hit_o   = 1'b0;
        fwd_stall_o = 1'b0;
        fwd_data_o  = '0;
        older_c     = ld_q_tail_i - head_q;
        any_alloc_c = 1'b0;
        ov_found_c  = 1'b0;
        ov_cover_c  = 1'b0;
        ov_off_c    = '0;
        ov_data_c   = '0;
        f_slot_c    = '0;
        st_end_c    = '0;
        ld_end_c    = EW'(ld_q_addr_i) + EW'(size_bytes(ld_q_size_i));
        for (int i = 0; i < DEPTH; i++) begin
            if (PW'(i) < older_c) begin
                f_slot_c = head_idx_c + IDX_W'(i);
                if (st_q[f_slot_c] == E_ALLOC) begin
                    any_alloc_c = 1'b1;
                end else if (st_q[f_slot_c] != E_EMPTY) begin
                    st_end_c = EW'(addr_q[f_slot_c]) + EW'(size_bytes(size_q[f_slot_c]));
                    if ((EW'(addr_q[f_slot_c]) < ld_end_c) && (EW'(ld_q_addr_i) < st_end_c)) begin
                        ov_found_c = 1'b1;
                        ov_cover_c = (addr_q[f_slot_c] <= ld_q_addr_i) && (ld_end_c <= st_end_c);
                        ov_off_c   = ld_q_addr_i[2:0] - addr_q[f_slot_c][2:0];
                        ov_data_c  = data_q[f_slot_c];
                    end
                end
            end
        end
        if (ld_q_valid_i) begin
            if (any_alloc_c) begin
                fwd_stall_o = 1'b1;
            end else if (ov_found_c) begin
                if (ov_cover_c) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = (ov_data_c >> {ov_off_c, 3'b000}) & size_mask(ld_q_size_i);
                end else begin
                    fwd_stall_o = 1'b1;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                st_q[j]   <= E_EMPTY;
                addr_q[j] <= '0;
                data_q[j] <= '0;
                size_q[j] <= '0;
            end
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            for (int j = 0; j < DEPTH; j++) begin
                st_q[j]   <= st_d[j];
                addr_q[j] <= addr_d[j];
                data_q[j] <= data_d[j];
                size_q[j] <= size_d[j];
            end
        end
    end

    // Dispatch never allocates beyond the free entries.
    a_alloc_fits: assert property (@(posedge clock_i) disable iff (!reset_ni)
                                   except_i || alloc_ok_c);

    // ROB only retires stores whose address and data are resolved.
    a_retire_ready: assert property (@(posedge clock_i) disable iff (!reset_ni)
                                     retire_ok_c);

    // Forwarding outcomes are mutually exclusive.
    a_fwd_excl: assert property (@(posedge clock_i) disable iff (!reset_ni)
                                 !(fwd_hit_o && fwd_stall_o));

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd: allocation/wrap, drain backpressure, forwarding,
// squash and asynchronous reset.
module tb_store_queue_fwd;

    localparam int unsigned WAYS   = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ROB    = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned PW     = 5;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned RC_W   = 3;

    logic                   clock_i = 1'b0;
    logic                   reset_ni;
    logic                   except_i;
    logic [WAYS-1:0]        alloc_en_i;
    logic [WAYS*ROB_W-1:0]  alloc_rob_idx_i;
    logic [WAYS*2-1:0]      alloc_size_i;
    logic [WAYS*IDX_W-1:0]  alloc_idx_o;
    logic [PW-1:0]          sq_tail_o;
    logic [PW-1:0]          free_cnt_o;
    logic [WAYS-1:0]        exe_valid_i;
    logic [WAYS*IDX_W-1:0]  exe_sq_idx_i;
    logic [WAYS*ADDR_W-1:0] exe_addr_i;
    logic [WAYS*64-1:0]     exe_data_i;
    logic [RC_W-1:0]        retire_cnt_i;
    logic                   ld_q_valid_i;
    logic [ADDR_W-1:0]      ld_q_addr_i;
    logic [1:0]             ld_q_size_i;
    logic [PW-1:0]          ld_q_tail_i;
    logic                   fwd_hit_o;
    logic [63:0]            fwd_data_o;
    logic                   fwd_stall_o;
    logic                   wr_valid_o;
    logic [ADDR_W-1:0]      wr_addr_o;
    logic [63:0]            wr_data_o;
    logic [1:0]             wr_size_o;
    logic                   wr_ready_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock_i = ~clock_i;

    store_queue_fwd #(
        .WAYS  (WAYS),
        .DEPTH (DEPTH),
        .ROB   (ROB),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .except_i       (except_i),
        .alloc_en_i     (alloc_en_i),
        .alloc_rob_idx_i(alloc_rob_idx_i),
        .alloc_size_i   (alloc_size_i),
        .alloc_idx_o    (alloc_idx_o),
        .sq_tail_o      (sq_tail_o),
        .free_cnt_o     (free_cnt_o),
        .exe_valid_i    (exe_valid_i),
        .exe_sq_idx_i   (exe_sq_idx_i),
        .exe_addr_i     (exe_addr_i),
        .exe_data_i     (exe_data_i),
        .retire_cnt_i   (retire_cnt_i),
        .ld_q_valid_i   (ld_q_valid_i),
        .ld_q_addr_i    (ld_q_addr_i),
        .ld_q_size_i    (ld_q_size_i),
        .ld_q_tail_i    (ld_q_tail_i),
        .fwd_hit_o      (fwd_hit_o),
        .fwd_data_o     (fwd_data_o),
        .fwd_stall_o    (fwd_stall_o),
        .wr_valid_o     (wr_valid_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_size_o      (wr_size_o),
        .wr_ready_i     (wr_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        except_i        = 1'b0;
        alloc_en_i      = '0;
        alloc_rob_idx_i = '0;
        alloc_size_i    = '0;
        exe_valid_i     = '0;
        exe_sq_idx_i    = '0;
        exe_addr_i      = '0;
        exe_data_i      = '0;
        retire_cnt_i    = '0;
        ld_q_valid_i    = 1'b0;
        ld_q_addr_i     = '0;
        ld_q_size_i     = '0;
        ld_q_tail_i     = '0;
        wr_ready_i      = 1'b0;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        idle();
        repeat (2) @(posedge clock_i);
        #1 reset_ni = 1'b1;
        #1;
    endtask

    task automatic exe_lane(input int k, input logic [3:0] slot, input logic [31:0] a,
                            input logic [63:0] d);
        exe_valid_i[k]             = 1'b1;
        exe_sq_idx_i[k*IDX_W +: 4] = slot;
        exe_addr_i[k*ADDR_W +: 32] = a;
        exe_data_i[k*64 +: 64]     = d;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic [4:0] t);
        ld_q_valid_i = 1'b1;
        ld_q_addr_i  = a;
        ld_q_size_i  = s;
        ld_q_tail_i  = t;
        #1;
    endtask

    initial begin
        logic [15:0] exp_idx;
        int s;

        // Reset state and fill to full over four cycles.
        do_reset();
        chk("rst_free", 64'(free_cnt_o), 64'd16);
        chk("rst_tail", 64'(sq_tail_o), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("rst_alloc_idx", 64'(alloc_idx_o), 64'h3210);
        load(32'h0, 2'd2, 5'd4);
        chk("rst_fwd_hit", 64'(fwd_hit_o), 64'd0);
        chk("rst_fwd_stall", 64'(fwd_stall_o), 64'd0);
        idle();
        for (int c = 0; c < 4; c++) begin
            alloc_en_i   = 4'hF;
            alloc_size_i = 8'hFF;
            #1;
            for (int k = 0; k < 4; k++) exp_idx[k*4 +: 4] = 4'(4*c + k);
            chk("fill_alloc_idx", 64'(alloc_idx_o), 64'(exp_idx));
            tick();
        end
        idle();
        #1;
        chk("full_free", 64'(free_cnt_o), 64'd0);
        chk("full_tail", 64'(sq_tail_o), 64'd16);
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                s = 4*c + k;
                exe_lane(k, 4'(s), 32'h1000 + 32'(8*s), {32'hD000_0000, 32'(s)});
            end
            tick();
        end
        idle();
        retire_cnt_i = 3'd4;
        tick();
        retire_cnt_i = 3'd0;
        for (int i = 0; i < 4; i++) begin
            wr_ready_i = 1'b1;
            #1;
            chk("drain_valid", 64'(wr_valid_o), 64'd1);
            chk("drain_addr", 64'(wr_addr_o), 64'(32'h1000 + 32'(8*i)));
            chk("drain_data", wr_data_o, {32'hD000_0000, 32'(i)});
            tick();
        end
        wr_ready_i = 1'b0;
        #1;
        chk("drain_free", 64'(free_cnt_o), 64'd4);
        chk("drain_stop", 64'(wr_valid_o), 64'd0);
        alloc_en_i = 4'hF;
        #1;
        chk("wrap_alloc_idx", 64'(alloc_idx_o), 64'h3210);
        tick();
        idle();
        #1;
        chk("wrap_free", 64'(free_cnt_o), 64'd0);
        chk("wrap_tail", 64'(sq_tail_o), 64'd20);

        // Single DOUBLE store: forwarding cases, then drain under backpressure.
        do_reset();
        alloc_en_i   = 4'b0001;
        alloc_size_i = 8'h03;
        #1;
        chk("one_alloc_idx", 64'(alloc_idx_o), 64'h3210);
        tick();
        idle();
        #1;
        chk("one_tail", 64'(sq_tail_o), 64'd1);
        chk("one_free", 64'(free_cnt_o), 64'd15);
        exe_lane(0, 4'd0, 32'h100, 64'h1122_3344_5566_7788);
        tick();
        idle();
        load(32'h104, 2'd2, 5'd1);
        chk("fw_word_hit", 64'(fwd_hit_o), 64'd1);
        chk("fw_word_data", fwd_data_o, 64'h1122_3344);
        chk("fw_word_stall", 64'(fwd_stall_o), 64'd0);
        load(32'h107, 2'd0, 5'd1);
        chk("fw_byte_data", fwd_data_o, 64'h11);
        load(32'h100, 2'd1, 5'd1);
        chk("fw_half_data", fwd_data_o, 64'h7788);
        load(32'h104, 2'd3, 5'd1);
        chk("fw_part_stall", 64'(fwd_stall_o), 64'd1);
        chk("fw_part_hit", 64'(fwd_hit_o), 64'd0);
        load(32'h200, 2'd2, 5'd1);
        chk("fw_miss_hit", 64'(fwd_hit_o), 64'd0);
        chk("fw_miss_stall", 64'(fwd_stall_o), 64'd0);
        load(32'h104, 2'd2, 5'd0);
        chk("fw_younger_hit", 64'(fwd_hit_o), 64'd0);
        load(32'h104, 2'd2, 5'd1);
        ld_q_valid_i = 1'b0;
        #1;
        chk("fw_novalid_hit", 64'(fwd_hit_o), 64'd0);
        idle();
        retire_cnt_i = 3'd1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 64'(wr_valid_o), 64'd1);
            chk("bp_addr", 64'(wr_addr_o), 64'h100);
            chk("bp_data", wr_data_o, 64'h1122_3344_5566_7788);
            chk("bp_size", 64'(wr_size_o), 64'd3);
            tick();
        end
        load(32'h104, 2'd2, 5'd1);
        chk("fw_commit_hit", 64'(fwd_hit_o), 64'd1);
        idle();
        wr_ready_i = 1'b1;
        #1;
        chk("bp_go_valid", 64'(wr_valid_o), 64'd1);
        tick();
        wr_ready_i = 1'b0;
        #1;
        chk("bp_done_valid", 64'(wr_valid_o), 64'd0);
        chk("bp_done_free", 64'(free_cnt_o), 64'd16);

        // Older ALLOC stalls; partial overlap with youngest store stalls.
        do_reset();
        alloc_en_i   = 4'b0011;
        alloc_size_i = 8'h03;
        tick();
        idle();
        load(32'h104, 2'd2, 5'd2);
        chk("alloc_stall", 64'(fwd_stall_o), 64'd1);
        chk("alloc_hit", 64'(fwd_hit_o), 64'd0);
        idle();
        exe_lane(0, 4'd0, 32'h100, 64'h1122_3344_5566_7788);
        exe_lane(1, 4'd1, 32'h104, 64'hAB);
        tick();
        idle();
        load(32'h104, 2'd2, 5'd2);
        chk("byte_part_stall", 64'(fwd_stall_o), 64'd1);
        load(32'h104, 2'd0, 5'd2);
        chk("young_byte_hit", 64'(fwd_hit_o), 64'd1);
        chk("young_byte_data", fwd_data_o, 64'hAB);
        load(32'h104, 2'd0, 5'd1);
        chk("old_byte_data", fwd_data_o, 64'h44);
        idle();
        alloc_en_i   = 4'b0001;
        alloc_size_i = 8'h02;
        tick();
        idle();
        load(32'h300, 2'd2, 5'd3);
        chk("unk_addr_stall", 64'(fwd_stall_o), 64'd1);
        load(32'h104, 2'd0, 5'd2);
        chk("unk_not_older", 64'(fwd_data_o), 64'hAB);
        idle();

        // Squash: six stores, two retire with except and a same-cycle alloc.
        do_reset();
        alloc_en_i = 4'hF;
        tick();
        alloc_en_i = 4'b0011;
        tick();
        idle();
        for (int k = 0; k < 4; k++) exe_lane(k, 4'(k), 32'h2000 + 32'(8*k), 64'(k + 10));
        tick();
        idle();
        exe_lane(0, 4'd4, 32'h2020, 64'd14);
        exe_lane(1, 4'd5, 32'h2028, 64'd15);
        tick();
        idle();
        retire_cnt_i = 3'd2;
        except_i     = 1'b1;
        alloc_en_i   = 4'b0011;
        tick();
        idle();
        #1;
        chk("exc_tail", 64'(sq_tail_o), 64'd2);
        chk("exc_free", 64'(free_cnt_o), 64'd14);
        chk("exc_alloc_idx", 64'(alloc_idx_o), 64'h5432);
        wr_ready_i = 1'b1;
        #1;
        chk("exc_drain0_valid", 64'(wr_valid_o), 64'd1);
        chk("exc_drain0_addr", 64'(wr_addr_o), 64'h2000);
        tick();
        chk("exc_drain1_addr", 64'(wr_addr_o), 64'h2008);
        chk("exc_drain1_data", wr_data_o, 64'd11);
        tick();
        wr_ready_i = 1'b0;
        #1;
        chk("exc_empty_valid", 64'(wr_valid_o), 64'd0);
        chk("exc_empty_free", 64'(free_cnt_o), 64'd16);
        exe_lane(0, 4'd4, 32'h3000, 64'd1);
        tick();
        idle();
        load(32'h3000, 2'd0, 5'd5);
        chk("squash_exe_hit", 64'(fwd_hit_o), 64'd0);
        chk("squash_exe_stall", 64'(fwd_stall_o), 64'd0);
        idle();

        // Asynchronous reset while a committed store is offered.
        do_reset();
        alloc_en_i   = 4'b0001;
        alloc_size_i = 8'h03;
        tick();
        idle();
        exe_lane(0, 4'd0, 32'h400, 64'h55);
        tick();
        idle();
        retire_cnt_i = 3'd1;
        tick();
        idle();
        #1;
        chk("ar_pre_valid", 64'(wr_valid_o), 64'd1);
        reset_ni = 1'b0;
        #1;
        chk("ar_valid", 64'(wr_valid_o), 64'd0);
        chk("ar_free", 64'(free_cnt_o), 64'd16);
        tick();
        reset_ni = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
